// File: rtl/pcie_us_msi_pkg.sv
// Shared types and helpers for the UltraScale PCIe multi-vector MSI controller.
// Holds the FSM state encoding and the request-to-vector mapping.
package pcie_us_msi_pkg;

  localparam int MAX_VECTORS = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT,
    ST_HOLD
  } msi_state_e;

  // Vector count is 1 << mm, clamped to 32, so the map is a low-bit mask.
  function automatic logic [4:0] vec_map(
    input logic [4:0] idx,
    input logic [2:0] mm
  );
    logic [4:0] m;
    m = (mm >= 3'd5) ? 5'h1f : 5'((6'd1 << mm) - 6'd1);
    return idx & m;
  endfunction

endpackage

// File: rtl/pcie_us_msi_rr_arb.sv
// Round-robin grant over the eligible request lines.
// Search starts one past the last grant and wraps around.
module pcie_us_msi_rr_arb #(
  parameter int N = 32,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          vld,
  output logic [IW-1:0] idx
);

  int j;

  // Walk from farthest to nearest so the nearest request wins.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    j   = 0;
    for (int k = N; k >= 1; k--) begin
      j = int'(last) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        vld = 1'b1;
        idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/pcie_us_msi_ctrl.sv
// Multi-vector MSI controller: latches irq pulses, arbitrates, sends, retries.
// Define PCIE_US_MSI_HOLDOFF_EN to enforce `holdoff` idle cycles after sent.
module pcie_us_msi_ctrl
  import pcie_us_msi_pkg::*;
#(
  parameter int IRQ_COUNT     = 32,
  parameter int RETRY_MAX     = 3,
  parameter int HOLDOFF_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [IRQ_COUNT-1:0]     irq,
  input  logic [HOLDOFF_WIDTH-1:0] holdoff,
  input  logic [3:0]               cfg_interrupt_msi_enable,
  input  logic [11:0]              cfg_interrupt_msi_mmenable,
  input  logic                     cfg_interrupt_msi_mask_update,
  input  logic [31:0]              cfg_interrupt_msi_data,
  output logic [3:0]               cfg_interrupt_msi_select,
  output logic [31:0]              cfg_interrupt_msi_int,
  input  logic                     cfg_interrupt_msi_sent,
  input  logic                     cfg_interrupt_msi_fail,
  output logic [31:0]              cfg_interrupt_msi_pending_status,
  output logic                     cfg_interrupt_msi_pending_status_data_enable,
  output logic [3:0]               cfg_interrupt_msi_pending_status_function_num,
  output logic [2:0]               cfg_interrupt_msi_attr,
  output logic                     cfg_interrupt_msi_tph_present,
  output logic [1:0]               cfg_interrupt_msi_tph_type,
  output logic [8:0]               cfg_interrupt_msi_tph_st_tag,
  output logic [3:0]               cfg_interrupt_msi_function_number,
  output logic                     irq_drop
);

  localparam int IW = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;

  msi_state_e state, state_n;

  logic [IRQ_COUNT-1:0] pending, elig, clr;
  logic [MAX_VECTORS-1:0] mask, pv, ps_q, ps_prev;
  logic [3:0] retry;
  logic [IW-1:0] g, last_g, arb_idx;
  logic [4:0] gv;
  logic arb_vld, grant, clr_g, drop, rinc, rclr;
  logic de_q, drop_q;
  logic [2:0] mm;
  logic en;

  assign mm = cfg_interrupt_msi_mmenable[2:0];
  assign en = cfg_interrupt_msi_enable[0];

  always_comb begin
    elig = '0;
    pv   = '0;
    clr  = '0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      elig[i] = pending[i] & ~mask[vec_map(5'(i), mm)] & en;
      pv[vec_map(5'(i), mm)] = pv[vec_map(5'(i), mm)] | pending[i];
      clr[i] = clr_g && (g == IW'(i));
    end
  end

  pcie_us_msi_rr_arb #(.N(IRQ_COUNT)) u_arb (
    .req  (elig),
    .last (last_g),
    .vld  (arb_vld),
    .idx  (arb_idx)
  );

`ifdef PCIE_US_MSI_HOLDOFF_EN
  logic [HOLDOFF_WIDTH-1:0] hcnt;
  logic hold_done;

  // Exit after `holdoff` cycles in HOLD; zero still costs one cycle.
  assign hold_done =
    ({1'b0, hcnt} + (HOLDOFF_WIDTH+1)'(1)) >= {1'b0, holdoff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                hcnt <= '0;
    else if (state == ST_HOLD) hcnt <= hcnt + 1'b1;
    else                       hcnt <= '0;
  end
`else
  logic unused_holdoff;
  assign unused_holdoff = ^holdoff;
`endif

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    clr_g   = 1'b0;
    drop    = 1'b0;
    rinc    = 1'b0;
    rclr    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (arb_vld) begin
          grant   = 1'b1;
          state_n = ST_SEND;
        end
      end
      ST_SEND: state_n = ST_WAIT;
      ST_WAIT: begin
        if (cfg_interrupt_msi_sent) begin
          clr_g = 1'b1;
          rclr  = 1'b1;
`ifdef PCIE_US_MSI_HOLDOFF_EN
          state_n = ST_HOLD;
`else
          state_n = ST_IDLE;
`endif
        end else if (cfg_interrupt_msi_fail) begin
          state_n = ST_IDLE;
          if (retry == 4'(RETRY_MAX)) begin
            clr_g = 1'b1;
            drop  = 1'b1;
            rclr  = 1'b1;
          end else begin
            rinc = 1'b1;
          end
        end
      end
      ST_HOLD: begin
`ifdef PCIE_US_MSI_HOLDOFF_EN
        if (hold_done) state_n = ST_IDLE;
`else
        state_n = ST_IDLE;
`endif
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
      mask    <= '0;
      retry   <= '0;
      g       <= '0;
      gv      <= '0;
      last_g  <= IW'(IRQ_COUNT - 1);
      ps_q    <= '0;
      ps_prev <= '0;
      de_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= (pending & ~clr) | irq;
      if (cfg_interrupt_msi_mask_update) mask <= cfg_interrupt_msi_data;
      if (rclr)      retry <= '0;
      else if (rinc) retry <= retry + 4'd1;
      if (grant) begin
        g      <= arb_idx;
        gv     <= vec_map(5'(arb_idx), mm);
        last_g <= arb_idx;
      end
      ps_q    <= pv;
      ps_prev <= ps_q;
      de_q    <= (ps_q != ps_prev);
      drop_q  <= drop;
    end
  end

  always_comb begin
    cfg_interrupt_msi_int = '0;
    if (state == ST_SEND) cfg_interrupt_msi_int[gv] = 1'b1;
  end

  logic unused_cfg;
  assign unused_cfg = ^{cfg_interrupt_msi_enable[3:1],
                        cfg_interrupt_msi_mmenable[11:3]};

  assign cfg_interrupt_msi_pending_status              = ps_q;
  assign cfg_interrupt_msi_pending_status_data_enable  = de_q;
  assign irq_drop                                      = drop_q;
  assign cfg_interrupt_msi_select                      = 4'd0;
  assign cfg_interrupt_msi_pending_status_function_num = 4'd0;
  assign cfg_interrupt_msi_attr                        = 3'd0;
  assign cfg_interrupt_msi_tph_present                 = 1'b0;
  assign cfg_interrupt_msi_tph_type                    = 2'd0;
  assign cfg_interrupt_msi_tph_st_tag                  = 9'd0;
  assign cfg_interrupt_msi_function_number             = 4'd0;

endmodule
